flag_service_sequencer: RTL and testbench
=========================================

Name: flag_service_sequencer

Overview:
- Reader/consumer side of a bank of set/clear latches (interrupt pending flags, APU status flags).
- Samples the latched values and selects the highest-priority enabled flag.
- Runs a request/accept/done handshake with the servicing agent (CPU sequencer or DMA), then emits a one-cycle clear pulse back to that latch bit.
- Sits between the flag latch bank and the core control logic.

Parameters:
- P_width, 4: number of flag sources; width of the value, mask and clear vectors.
- P_index_width, 2: width of O_index; must be at least clog2(P_width), minimum 1.
- P_timeout, 15: maximum SERVICE cycles waiting for I_done; 0 disables the timeout.

Ports:
- I_clock  input  1  single clock; all state updates on its rising edge.
- I_reset  input  1  reset, asynchronous, active-low.
- I_value  input  P_width  latched flag values from the latch bank.
- I_mask  input  P_width  per-flag enable; only bits with I_value & I_mask are eligible.
- O_request  output  1  service request to the agent.
- O_index  output  P_index_width  index of the flag being requested or serviced.
- I_accept  input  1  agent accepts the request; sampled only in REQUEST.
- I_done  input  1  agent finished; sampled only in SERVICE.
- O_clear  output  P_width  one-hot, one-cycle clear pulse to the latch bank.
- O_busy  output  1  high in any state other than IDLE.
- O_timeout  output  1  one-cycle pulse when SERVICE times out.
- O_fault  output  1  sticky; set by any timeout, cleared only by reset.

Behaviour:
- Reset (asynchronous, I_reset low):
  - State goes to IDLE and the timeout counter to 0.
  - O_request, O_index, O_clear, O_busy, O_timeout and O_fault are all 0.
  - No clear pulse is emitted on reset or on reset release.
- All outputs are registered. They are never combinational from inputs.
- States: IDLE, REQUEST, SERVICE, CLEAR, SETTLE.
- IDLE:
  - Eligible vector is I_value & I_mask. Selection is fixed priority, lowest index wins.
  - If any bit is eligible, capture its index into O_index, go to REQUEST and assert O_request. Latency is 1 cycle from the eligible sample.
  - If no bit is eligible, stay in IDLE.
- REQUEST:
  - O_request is high. O_index is held stable and is not re-arbitrated, even if a lower index becomes eligible.
  - If I_accept is high, go to SERVICE and drop O_request.
  - If I_accept is low and the captured flag is no longer eligible, this is a withdraw: go to IDLE, drop O_request, no clear pulse.
  - If I_accept is high in the same cycle the flag drops, accept wins and the sequence goes to SERVICE.
  - I_done is ignored in REQUEST.
- SERVICE:
  - O_index is held. The timeout counter increments each cycle.
  - If I_done is high, go to CLEAR.
  - Otherwise, if P_timeout is nonzero and the counter reaches P_timeout, go to CLEAR, pulse O_timeout for 1 cycle and set O_fault.
  - If I_done arrives in the same cycle as the timeout, I_done wins: no timeout pulse and no fault.
  - I_value and I_mask changes are ignored in SERVICE.
- CLEAR:
  - O_clear is one-hot at O_index for exactly 1 cycle. Next state is SETTLE.
- SETTLE:
  - Waits 1 cycle so the latch update is visible before re-arbitration; next state is IDLE.
  - The minimum IDLE-to-IDLE turnaround is 5 cycles.
- Timeout counter: clog2(P_timeout+1) bits wide, saturating, and cleared on entry to SERVICE.
- O_busy is high in REQUEST, SERVICE, CLEAR and SETTLE.
- A flag re-set by its source after CLEAR is serviced again on a later pass; events are not merged or counted.
- An asynchronous reset in any state aborts immediately. Any in-progress service gets no clear pulse, and the flag is re-requested after reset if it is still latched.

Test Plan:
- Reset with I_value=4'b1111 and I_mask=4'b1111 held → all outputs stay 0 while reset is low. O_request rises 1 cycle after the first post-reset rising edge with O_index=0.
- I_value=4'b0110, I_mask=4'b1111; pulse I_accept, then I_done 3 cycles later → O_index=1 and O_clear=4'b0010 for exactly 1 cycle. The bench then drives I_value=4'b0100, and index 2 is requested 1 cycle after returning to IDLE.
- I_value=4'b0001, I_mask=4'b1110 for 20 cycles → O_request and O_busy stay 0 throughout. Setting I_mask=4'b1111 → request with O_index=0 on the next cycle.
- Withdraw: request for index 0 is pending, then I_value drops to 4'b0000 with I_accept low → O_request falls the next cycle, O_clear stays 0, state returns to IDLE.
- Timeout, P_timeout=15: accept with no I_done → after 15 SERVICE cycles O_timeout pulses once and O_clear carries the one-hot for O_index. O_fault stays 1 until reset.
- Reset asserted in SERVICE (index 3 active) → outputs go to 0 asynchronously and no O_clear pulse appears. After release with I_value=4'b1000 still latched, index 3 is requested again.

Source files
------------

// File: rtl/flag_service_sequencer.sv
// Consumer side of a set/clear flag latch bank: picks the lowest-index enabled flag,
// runs request/accept/done with the servicing agent, then pulses a one-hot clear back.
module flag_service_sequencer #(
  parameter int P_width       = 4,
  parameter int P_index_width = 2,
  parameter int P_timeout     = 15
) (
  input  logic                     I_clock,
  input  logic                     I_reset,
  input  logic [P_width-1:0]       I_value,
  input  logic [P_width-1:0]       I_mask,
  output logic                     O_request,
  output logic [P_index_width-1:0] O_index,
  input  logic                     I_accept,
  input  logic                     I_done,
  output logic [P_width-1:0]       O_clear,
  output logic                     O_busy,
  output logic                     O_timeout,
  output logic                     O_fault
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CW = (P_timeout > 0) ? $clog2(P_timeout + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(P_timeout);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_SERVICE,
    ST_CLEAR,
    ST_SETTLE
  } state_t;

  state_t                     state_reg;
  logic [CW-1:0]              cnt_reg;
  logic [CW-1:0]              cnt_next;
  logic                       cnt_hit;
  logic [P_width-1:0]         eligible;
  logic [P_width-1:0]         clear_onehot;
  logic [P_index_width-1:0]   pick_index;
  logic                       captured_eligible;

  assign eligible = I_value & I_mask;

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    pick_index = '0;
    for (int i = P_width - 1; i >= 0; i--) begin
      if (eligible[i]) pick_index = P_index_width'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < P_width; gi++) begin : g_onehot
      assign clear_onehot[gi] = (O_index == P_index_width'(gi));
    end
  endgenerate

  assign captured_eligible = |(eligible & clear_onehot);
  assign cnt_next          = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
  assign cnt_hit           = (P_timeout != 0) && (cnt_next == CNT_LIMIT);

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      O_request <= 1'b0;
      O_index   <= '0;
      O_clear   <= '0;
      O_busy    <= 1'b0;
      O_timeout <= 1'b0;
      O_fault   <= 1'b0;
    end else begin
      O_clear   <= '0;
      O_timeout <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|eligible) begin
            state_reg <= ST_REQUEST;
            O_request <= 1'b1;
            O_index   <= pick_index;
            O_busy    <= 1'b1;
          end
        end
        ST_REQUEST: begin
          // Accept beats a simultaneous withdraw.
          if (I_accept) begin
            state_reg <= ST_SERVICE;
            O_request <= 1'b0;
            cnt_reg   <= '0;
          end else if (!captured_eligible) begin
            state_reg <= ST_IDLE;
            O_request <= 1'b0;
            O_busy    <= 1'b0;
          end
        end
        ST_SERVICE: begin
          cnt_reg <= cnt_next;
          if (I_done) begin
            state_reg <= ST_CLEAR;
            O_clear   <= clear_onehot;
          end else if (cnt_hit) begin
            state_reg <= ST_CLEAR;
            O_clear   <= clear_onehot;
            O_timeout <= 1'b1;
            O_fault   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_reg <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state_reg <= ST_IDLE;
          O_busy    <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          O_request <= 1'b0;
          O_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_service_sequencer.sv
// Bench for flag_service_sequencer: directed scenarios plus randomized transactions
// checked against a transaction-level expectation of the output bundle.
module tb_flag_service_sequencer;

  logic       I_clock;
  logic       I_reset;
  logic [3:0] I_value;
  logic [3:0] I_mask;
  logic       O_request;
  logic [1:0] O_index;
  logic       I_accept;
  logic       I_done;
  logic [3:0] O_clear;
  logic       O_busy;
  logic       O_timeout;
  logic       O_fault;

  int vectors;
  int miscompares;
  logic [9:0] obs;

  flag_service_sequencer #(
    .P_width(4),
    .P_index_width(2),
    .P_timeout(15)
  ) dut (
    .I_clock  (I_clock),
    .I_reset  (I_reset),
    .I_value  (I_value),
    .I_mask   (I_mask),
    .O_request(O_request),
    .O_index  (O_index),
    .I_accept (I_accept),
    .I_done   (I_done),
    .O_clear  (O_clear),
    .O_busy   (O_busy),
    .O_timeout(O_timeout),
    .O_fault  (O_fault)
  );

  assign obs = {O_request, O_index, O_clear, O_busy, O_timeout, O_fault};

  initial I_clock = 1'b0;
  always #5 I_clock = ~I_clock;

  // Expected output bundle: {request, index, clear, busy, timeout, fault}.
  function automatic logic [9:0] e(input logic rq, input logic [1:0] ix, input logic [3:0] cl,
                                   input logic bz, input logic to, input logic ft);
    return {rq, ix, cl, bz, to, ft};
  endfunction

  task automatic step();
    @(negedge I_clock);
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    I_reset = 1'b0; I_value = 4'b1111; I_mask = 4'b1111; I_accept = 1'b0; I_done = 1'b0;
    repeat (3) begin
      step();
      exp = e(0, 2'd0, 4'b0000, 0, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset_hold obs=%b exp=%b", obs, exp); end
    end
    I_reset = 1'b1;
    step();
    exp = e(1, 2'd0, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_first_req obs=%b exp=%b", obs, exp); end
    I_value = 4'b0000;
    step();
    exp = e(0, 2'd0, 4'b0000, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_withdraw obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_basic();
    logic [9:0] exp;
    I_value = 4'b0110; I_mask = 4'b1111;
    step();
    exp = e(1, 2'd1, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_req obs=%b exp=%b", obs, exp); end
    I_accept = 1'b1;
    step();
    I_accept = 1'b0;
    repeat (3) begin
      exp = e(0, 2'd1, 4'b0000, 1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL basic_service obs=%b exp=%b", obs, exp); end
      if (obs === exp && I_done === 1'b0 && $urandom_range(0, 0) == 0) begin end
      step();
    end
    I_done = 1'b0;
    $display("txn basic: value=0110 accepted, waiting done");
    I_done = 1'b1;
    step();
    exp = e(0, 2'd1, 4'b0010, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_clear obs=%b exp=%b", obs, exp); end
    I_done = 1'b0; I_value = 4'b0100;
    step();
    exp = e(0, 2'd1, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_settle obs=%b exp=%b", obs, exp); end
    step();
    exp = e(0, 2'd1, 4'b0000, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_idle obs=%b exp=%b", obs, exp); end
    step();
    exp = e(1, 2'd2, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_rereq obs=%b exp=%b", obs, exp); end
    I_value = 4'b0000;
    step();
    exp = e(0, 2'd2, 4'b0000, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL basic_withdraw obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_mask_withdraw();
    logic [9:0] exp;
    I_value = 4'b0001; I_mask = 4'b1110;
    repeat (20) begin
      step();
      exp = e(0, 2'd2, 4'b0000, 0, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL mask_block obs=%b exp=%b", obs, exp); end
    end
    I_mask = 4'b1111;
    step();
    exp = e(1, 2'd0, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL mask_open obs=%b exp=%b", obs, exp); end
    I_value = 4'b0000;
    repeat (2) begin
      step();
      exp = e(0, 2'd0, 4'b0000, 0, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL withdraw obs=%b exp=%b", obs, exp); end
    end
  endtask

  task automatic test_hold_accept_wins();
    logic [9:0] exp;
    I_value = 4'b0100;
    step();
    I_value = 4'b0101; I_done = 1'b1;
    step();
    exp = e(1, 2'd2, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hold_no_rearb obs=%b exp=%b", obs, exp); end
    I_value = 4'b0001; I_done = 1'b0; I_accept = 1'b1;
    step();
    exp = e(0, 2'd2, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL accept_wins obs=%b exp=%b", obs, exp); end
    I_accept = 1'b0; I_done = 1'b1;
    step();
    exp = e(0, 2'd2, 4'b0100, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hold_clear obs=%b exp=%b", obs, exp); end
    I_done = 1'b0; I_value = 4'b0000;
    repeat (2) step();
    exp = e(0, 2'd2, 4'b0000, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hold_idle obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_random(inout logic [1:0] last_idx);
    logic [9:0] exp;
    logic [3:0] v, m, elig;
    logic [1:0] idx;
    bit found;
    int a, d;
    for (int t = 0; t < 24; t++) begin
      v = 4'($urandom); m = 4'($urandom); elig = v & m;
      found = 0; idx = 2'd0;
      for (int b = 0; b < 4; b++) if (!found && elig[b]) begin idx = 2'(b); found = 1; end
      I_value = v; I_mask = m; I_accept = 1'b0; I_done = 1'b0;
      a = $urandom_range(0, 3); d = $urandom_range(0, 14);
      $display("txn %0d: value=%b mask=%b idx=%0d accept_wait=%0d done_wait=%0d", t, v, m, idx, a, d);
      step();
      if (!found) begin
        exp = e(0, last_idx, 4'b0000, 0, 0, 0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rnd_idle obs=%b exp=%b", obs, exp); end
        continue;
      end
      exp = e(1, idx, 4'b0000, 1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rnd_req obs=%b exp=%b", obs, exp); end
      for (int k = 0; k < a; k++) begin
        I_value = 4'($urandom) | (4'b0001 << idx);
        I_mask  = 4'($urandom) | (4'b0001 << idx);
        step();
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rnd_req_hold obs=%b exp=%b", obs, exp); end
      end
      I_accept = 1'b1; I_value = 4'($urandom); I_done = 1'($urandom);
      step();
      I_accept = 1'b0; I_done = 1'b0;
      exp = e(0, idx, 4'b0000, 1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rnd_service obs=%b exp=%b", obs, exp); end
      for (int k = 0; k < d; k++) begin
        I_value = 4'($urandom); I_mask = 4'($urandom);
        step();
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rnd_service_hold obs=%b exp=%b", obs, exp); end
      end
      I_done = 1'b1;
      step();
      exp = e(0, idx, 4'b0001 << idx, 1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rnd_clear obs=%b exp=%b", obs, exp); end
      I_done = 1'b0; I_value = 4'b0000;
      step();
      exp = e(0, idx, 4'b0000, 1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rnd_settle obs=%b exp=%b", obs, exp); end
      step();
      exp = e(0, idx, 4'b0000, 0, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rnd_idle_after obs=%b exp=%b", obs, exp); end
      last_idx = idx;
    end
    I_value = 4'b0000; I_mask = 4'b1111;
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    I_value = 4'b0001; I_mask = 4'b1111;
    step();
    I_accept = 1'b1;
    step();
    I_accept = 1'b0; I_done = 1'b1;
    step();
    exp = e(0, 2'd0, 4'b0001, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_clear obs=%b exp=%b", obs, exp); end
    I_done = 1'b0;
    repeat (2) step();
    exp = e(0, 2'd0, 4'b0000, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_idle obs=%b exp=%b", obs, exp); end
    step();
    exp = e(1, 2'd0, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_second_req obs=%b exp=%b", obs, exp); end
    I_value = 4'b0000;
    step();
  endtask

  task automatic test_done_at_timeout();
    logic [9:0] exp;
    I_value = 4'b1000;
    step();
    I_accept = 1'b1;
    step();
    I_accept = 1'b0;
    repeat (14) step();
    exp = e(0, 2'd3, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL tie_service15 obs=%b exp=%b", obs, exp); end
    I_done = 1'b1;
    step();
    exp = e(0, 2'd3, 4'b1000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL tie_done_wins obs=%b exp=%b", obs, exp); end
    I_done = 1'b0; I_value = 4'b0000;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    logic [9:0] exp;
    I_value = 4'b0010;
    step();
    I_accept = 1'b1;
    step();
    I_accept = 1'b0;
    for (int k = 2; k <= 15; k++) begin
      step();
      exp = e(0, 2'd1, 4'b0000, 1, 0, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL to_wait cycle=%0d obs=%b exp=%b", k, obs, exp); end
    end
    step();
    exp = e(0, 2'd1, 4'b0010, 1, 1, 1);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL to_pulse obs=%b exp=%b", obs, exp); end
    I_value = 4'b0000;
    step();
    exp = e(0, 2'd1, 4'b0000, 1, 0, 1);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL to_settle obs=%b exp=%b", obs, exp); end
    repeat (5) begin
      step();
      exp = e(0, 2'd1, 4'b0000, 0, 0, 1);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL to_fault_sticky obs=%b exp=%b", obs, exp); end
    end
  endtask

  task automatic test_reset_in_service();
    logic [9:0] exp;
    I_value = 4'b1000;
    step();
    I_accept = 1'b1;
    step();
    I_accept = 1'b0;
    step();
    exp = e(0, 2'd3, 4'b0000, 1, 0, 1);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rs_service obs=%b exp=%b", obs, exp); end
    #2 I_reset = 1'b0;
    #1;
    exp = e(0, 2'd0, 4'b0000, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rs_async obs=%b exp=%b", obs, exp); end
    repeat (2) begin
      step();
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rs_hold obs=%b exp=%b", obs, exp); end
    end
    I_reset = 1'b1;
    step();
    exp = e(1, 2'd3, 4'b0000, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rs_rereq obs=%b exp=%b", obs, exp); end
    I_value = 4'b0000;
    step();
  endtask

  initial begin
    logic [1:0] last_idx;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_mask_withdraw();
    test_hold_accept_wins();
    last_idx = 2'd2;
    test_random(last_idx);
    test_back_to_back();
    test_done_at_timeout();
    test_timeout();
    test_reset_in_service();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
